// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic [BIN_W-1:0]    i_bin;
    logic                i_start;
    logic                o_busy;
    logic                o_done;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_ovf;

    // producer of binary values (counter, bench)
    modport master (
        output i_bin,
        output i_start,
        input  o_busy,
        input  o_done,
        input  o_bcd,
        input  o_ovf
    );

    // the converter itself
    modport slave (
        input  i_bin,
        input  i_start,
        output o_busy,
        output o_done,
        output o_bcd,
        output o_ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - double-dabble binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(DIGITS) - 1;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_nx;
    logic [BIN_W-1:0] bin_q, bin_nx, bin_sh;
    logic [BCD_W-1:0] scr_q, scr_nx, scr_adj, scr_sh;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             pend_q, pend_nx;
    logic [BCD_W-1:0] bcd_q, bcd_nx;
    logic             ovf_q, ovf_nx;
    logic             done_q, done_nx;
    logic             in_ovf;

    // Values that cannot be shown in DIGITS decimal digits are saturated at the end;
    // carries out of the top nibble are simply dropped during the shift.
    assign in_ovf = ({{(64-BIN_W){1'b0}}, bus.i_bin} > MAX_DEC);

    // add-3 correction on every nibble that is 5 or more, all in parallel
    always_comb begin
        scr_adj = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
    end

    assign {scr_sh, bin_sh} = {scr_adj[BCD_W-2:0], bin_q, 1'b0};

    // next-state and datapath updates; outputs only move on the completing iteration
    always_comb begin
        state_nx = state_q;
        bin_nx   = bin_q;
        scr_nx   = scr_q;
        cnt_nx   = cnt_q;
        pend_nx  = pend_q;
        bcd_nx   = bcd_q;
        ovf_nx   = ovf_q;
        done_nx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    bin_nx   = bus.i_bin;
                    scr_nx   = '0;
                    cnt_nx   = '0;
                    pend_nx  = in_ovf;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                bin_nx = bin_sh;
                scr_nx = scr_sh;
                cnt_nx = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    bcd_nx   = pend_q ? ALL_NINES : scr_sh;
                    ovf_nx   = pend_q;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register; reset wins and discards any partial conversion
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            bin_q   <= bin_nx;
            scr_q   <= scr_nx;
            cnt_q   <= cnt_nx;
            pend_q  <= pend_nx;
            bcd_q   <= bcd_nx;
            ovf_q   <= ovf_nx;
            done_q  <= done_nx;
        end
    end

    assign bus.o_busy = (state_q == SHIFT);
    assign bus.o_done = done_q;
    assign bus.o_bcd  = bcd_q;
    assign bus.o_ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic mon_en = 1'b0;
    logic rst_at_edge = 1'b0;
    logic [15:0] prev_bcd = '0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int x;
        logic [15:0] r;
        if (v > 9999) return 16'h9999;
        x = v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // monitor: every o_done pops one expectation; o_bcd must not move otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.o_bcd), 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("bcd", 32'(bus.o_bcd), 32'(e.bcd));
                    check("ovf", 32'(bus.o_ovf), 32'(e.ovf));
                    check("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end else if (rst_at_edge) begin
                check("bcd_stable", 32'(bus.o_bcd), 32'(prev_bcd));
            end
            prev_bcd <= bus.o_bcd;
        end
    end

    // one accepted conversion; optional start pulse injected while busy
    task automatic convert(input int val, input logic [15:0] ebcd, input logic eovf,
                           input bit inject);
        exp_t e;
        bus.i_bin   = 14'(val);
        bus.i_start = 1'b1;
        @(negedge clk);
        e.bcd = ebcd;
        e.ovf = eovf;
        e.acc = cyc;
        sb.push_back(e);
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        check("busy_after_accept", 32'(bus.o_busy), 32'd1);
        for (int i = 1; i <= LAT; i++) begin
            if (inject && i == 5) begin
                bus.i_bin   = 14'd5678;
                bus.i_start = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
            if (i == LAT - 1) check("busy_last_iter", 32'(bus.o_busy), 32'd1);
        end
        bus.i_start = 1'b0;
        check("busy_at_done", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        int v;
        bus.i_bin   = '0;
        bus.i_start = 1'b0;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_bcd", 32'(bus.o_bcd), 32'd0);
        check("rst_ovf", 32'(bus.o_ovf), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        prev_bcd = bus.o_bcd;
        mon_en   = 1'b1;

        convert(0,    16'h0000, 1'b0, 1'b0);
        convert(9,    16'h0009, 1'b0, 1'b0);
        convert(255,  16'h0255, 1'b0, 1'b0);
        convert(1234, 16'h1234, 1'b0, 1'b0);
        convert(9999, 16'h9999, 1'b0, 1'b0);

        // abort a conversion at iteration 6; nothing may complete afterwards
        bus.i_bin   = 14'd1234;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_bcd", 32'(bus.o_bcd), 32'd0);
        check("midrst_ovf", 32'(bus.o_ovf), 32'd0);
        check("midrst_done", 32'(bus.o_done), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        convert(10000, 16'h9999, 1'b1, 1'b0);
        convert(42,    16'h0042, 1'b0, 1'b0);
        convert(16383, 16'h9999, 1'b1, 1'b0);

        convert(1234, 16'h1234, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // i_start held high: one accept every BIN_W+1 cycles
        bus.i_start = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            exp_t e;
            bus.i_bin = 14'(k);
            @(negedge clk);
            e.bcd = 16'(((k / 10) << 4) | (k % 10));
            e.ovf = 1'b0;
            e.acc = cyc;
            sb.push_back(e);
            repeat (LAT) @(negedge clk);
        end
        bus.i_start = 1'b0;
        repeat (5) @(negedge clk);

        for (int n = 0; n < 2000; n++) begin
            v = int'($urandom_range(0, 16383));
            convert(v, ref_bcd(v), (v > 9999) ? 1'b1 : 1'b0, 1'b0);
        end
        repeat (20) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using double-dabble (shift-add-3), one bit per clock.
- Sits between a binary value producer (e.g. the 8-bit dedicated-processor counter, zero-extended to 14 bits) and the 4-digit FND controller.
- Gives the display decimal digits without a wide combinational divider chain.
- Holds its last valid result between conversions so the display never shows intermediate values.

Parameters:
- BIN_W, 14, width of binary input; must satisfy 2^BIN_W - 1 >= 10^DIGITS - 1.
- DIGITS, 4, number of BCD output digits (output width 4*DIGITS).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on next rising clk edge).
- i_bin  input  BIN_W  unsigned binary value; sampled only on the edge that accepts i_start.
- i_start  input  1  conversion request, level-sampled each edge.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when o_bcd/o_ovf are updated.
- o_bcd  output  4*DIGITS  packed BCD result; digit 0 (ones) in [3:0].
- o_ovf  output  1  high when the last accepted i_bin exceeded 10^DIGITS - 1.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, o_busy=0, o_done=0, o_bcd=0, o_ovf=0, internal shift/count registers cleared. Reset has priority over all other inputs and aborts any conversion in progress. o_bcd is cleared, not left with partial data.
- FSM states:
  - IDLE: o_busy=0. An edge with i_start=1 is the accept edge (edge 0).
    - Latch i_bin into the shift register, clear the BCD scratch and the iteration counter.
    - Latch ovf_pending = (i_bin > 10^DIGITS - 1).
    - Go to SHIFT; o_busy=1 from edge 0.
  - SHIFT: one iteration per edge, edges 1..BIN_W.
    - Each BCD scratch nibble >= 5 gets +3 (all nibbles in parallel).
    - Then {scratch, binreg} shifts left by 1, MSB of binreg entering scratch bit 0.
    - Iteration counter is ceil(log2(BIN_W+1)) bits and increments each edge.
  - Edge BIN_W performs the final iteration and, in the same edge:
    - o_bcd <= final scratch, or all-9s (16'h9999 for DIGITS=4) when ovf_pending.
    - o_ovf <= ovf_pending; o_done <= 1; o_busy <= 0; state -> IDLE.
- Scratch is DIGITS*4 bits. Carries out of the top nibble are discarded, which is why overflow is saturated separately.
- Latency: o_done is visible in the cycle after edge BIN_W, which is BIN_W cycles after the accept edge (14 for the default).
- o_done is high for exactly one cycle. The edge after it clears o_done unless a new conversion completes.
- i_start while o_busy=1 is ignored (no queueing); i_bin changes while busy have no effect.
- i_start=1 in the same cycle o_done=1 is accepted (state is already IDLE), giving back-to-back conversions every BIN_W+1 cycles.
- i_start held high continuously: free-running re-conversion, one new result every BIN_W+1 cycles.
- o_bcd and o_ovf change only on a completing edge or on reset; stable at all other times.
- Input 0 yields o_bcd=0, o_ovf=0. The maximum in-range value 9999 yields 16'h9999 with o_ovf=0.

Test Plan:
- Reset held low 3 cycles, then released -> o_bcd=0, o_ovf=0, o_busy=0, o_done=0. Pulse reset low mid-conversion (SHIFT, iteration 6) -> o_busy=0 and o_bcd=0 on the next edge; no o_done pulse follows.
- Conversion values each -> o_done exactly 14 cycles after the accept edge, o_ovf=0:
  - i_bin=0 -> o_bcd=16'h0000
  - i_bin=9 -> 16'h0009
  - i_bin=255 -> 16'h0255
  - i_bin=1234 -> 16'h1234
  - i_bin=9999 -> 16'h9999
- Overflow: i_bin=10000 -> o_bcd=16'h9999, o_ovf=1. Next i_bin=42 -> o_bcd=16'h0042, o_ovf=0. i_bin=16383 -> 16'h9999, o_ovf=1.
- Start while busy: accept 1234, pulse i_start with i_bin=5678 at iteration 5 -> single o_done, o_bcd=16'h1234, o_busy timing unchanged.
- Back-to-back: i_start held high with i_bin stepping 0..20 per accept -> results 16'h0000..16'h0020 in order, one o_done every 15 cycles. o_bcd stable between o_done pulses.
- Randomised 2000 values over 0..16383 checked against a reference model -> exact o_bcd/o_ovf match and fixed latency.
